// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame sequencer.
// State encoding and bus widths used by the frame controller.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam int BIT_WIDTH_D = 16;
   localparam int N_D         = 9;
   localparam int FFT_SIZE_D  = 512;
   localparam int NOTE_W      = 10;

endpackage

// File: rtl/fft_frame_ctrl_sample_decimator.sv
// Sample decimator: keeps one of every DECIM valid samples.
// The first valid sample after a clear is always kept.
module sample_decimator #(
   parameter int DECIM = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   input  logic sample_valid,
   output logic keep
);

   localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

   logic [CW-1:0] cnt;

   // phase counter over valid samples, frozen outside a run
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (run && sample_valid)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign keep = run && sample_valid && (cnt == '0);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between the audio sample stream and fftfull.
// Loads one decimated frame, starts the transform, captures the note.
module fft_frame_ctrl
   import fft_pkg::*;
#(
   parameter int BIT_WIDTH = BIT_WIDTH_D,
   parameter int N         = N_D,
   parameter int FFT_SIZE  = FFT_SIZE_D,
   parameter int DECIM     = 4,
   parameter int TIMEOUT   = 65535
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 sample_valid,
   input  logic [BIT_WIDTH-1:0] sample,
   input  logic                 fft_done,
   input  logic [NOTE_W-1:0]    note_in,
   output logic                 fft_load,
   output logic                 fft_start,
   output logic [N-1:0]         add_rd,
   output logic [BIT_WIDTH-1:0] din,
   output logic [NOTE_W-1:0]    note,
   output logic                 note_valid,
   output logic                 busy,
   output logic                 overrun,
   output logic                 timeout_err,
   input  logic                 clr_flags
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [N-1:0]  LAST_ADDR = N'(FFT_SIZE - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

   state_t        state;
   state_t        state_nxt;
   logic          in_load;
   logic          in_wait;
   logic          load_entry;
   logic          keep;
   logic          done_q;
   logic          done_rise;
   logic          to_hit;
   logic          last_wr;
   logic          start_pend;
   logic [N-1:0]  addr;
   logic [TW-1:0] tcnt;

   sample_decimator #(
      .DECIM(DECIM)
   ) u_decim (
      .clk          (clk),
      .reset        (reset),
      .run          (in_load | in_wait),
      .clear        (load_entry),
      .sample_valid (sample_valid),
      .keep         (keep)
   );

   assign done_rise  = fft_done && !done_q;
   assign to_hit     = in_wait && (tcnt == TO_LAST);
   assign last_wr    = in_load && keep && (addr == LAST_ADDR);
   assign load_entry = (state_nxt == LOAD) && (state != LOAD);

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state: done edge beats timeout, enable only aborts LOAD
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (enable) state_nxt = LOAD;
         LOAD: begin
            if (!enable)
               state_nxt = IDLE;
            else if (last_wr)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (done_rise)
               state_nxt = enable ? LOAD : IDLE;
            else if (to_hit)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state decode
   always_comb begin
      busy    = 1'b0;
      in_load = 1'b0;
      in_wait = 1'b0;
      unique case (state)
         LOAD: begin
            busy    = 1'b1;
            in_load = 1'b1;
         end
         WAIT: begin
            busy    = 1'b1;
            in_wait = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // write port, start pulse and note capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fft_load   <= 1'b0;
         add_rd     <= '0;
         din        <= '0;
         start_pend <= 1'b0;
         fft_start  <= 1'b0;
         done_q     <= 1'b0;
         note       <= '0;
         note_valid <= 1'b0;
      end else begin
         fft_load   <= in_load && keep;
         if (in_load && keep) begin
            add_rd <= addr;
            din    <= sample;
         end
         start_pend <= last_wr && enable;
         fft_start  <= start_pend;
         done_q     <= fft_done;
         note_valid <= in_wait && done_rise;
         if (in_wait && done_rise)
            note <= note_in;
      end
   end

   // frame address and saturating wait timer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr <= '0;
         tcnt <= '0;
      end else begin
         if (!in_load || !enable)
            addr <= '0;
         else if (keep)
            addr <= addr + 1'b1;
         if (!in_wait)
            tcnt <= '0;
         else if (tcnt != TO_MAX)
            tcnt <= tcnt + 1'b1;
      end
   end

   // sticky error flags, a new event outranks a clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (in_wait && keep)
            overrun <= 1'b1;
         else if (clr_flags)
            overrun <= 1'b0;
         if (to_hit && !done_rise)
            timeout_err <= 1'b1;
         else if (clr_flags)
            timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: random sample gaps and values,
// expected writes derived from the list of samples sent.
module tb_fft_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        sample_valid;
   logic [15:0] sample;
   logic        fft_done;
   logic [9:0]  note_in;
   logic        clr_flags;

   logic        fft_load, fft_start, note_valid, busy;
   logic        overrun, timeout_err;
   logic [8:0]  add_rd;
   logic [15:0] din;
   logic [9:0]  note;

   logic        fft_load_t, fft_start_t, note_valid_t, busy_t;
   logic        overrun_t, timeout_err_t;
   logic [8:0]  add_rd_t;
   logic [15:0] din_t;
   logic [9:0]  note_t;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [8:0]  wa_q[$];
   logic [15:0] wd_q[$];
   logic [15:0] sent_q[$];
   int last_ld = 0, n_start = 0, start_cyc = 0, n_nv = 0;
   int last_ld_t = 0, n_nv_t = 0, te_cyc = 0, te_cnt = 0;
   logic te_prev = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft_frame_ctrl #(.TIMEOUT(65535)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .sample_valid(sample_valid), .sample(sample),
      .fft_done(fft_done), .note_in(note_in),
      .fft_load(fft_load), .fft_start(fft_start),
      .add_rd(add_rd), .din(din), .note(note),
      .note_valid(note_valid), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err),
      .clr_flags(clr_flags)
   );

   fft_frame_ctrl #(.TIMEOUT(100)) dut_to (
      .clk(clk), .reset(reset), .enable(enable),
      .sample_valid(sample_valid), .sample(sample),
      .fft_done(fft_done), .note_in(note_in),
      .fft_load(fft_load_t), .fft_start(fft_start_t),
      .add_rd(add_rd_t), .din(din_t), .note(note_t),
      .note_valid(note_valid_t), .busy(busy_t),
      .overrun(overrun_t), .timeout_err(timeout_err_t),
      .clr_flags(clr_flags)
   );

   // event recorder, sampled mid-cycle
   always @(negedge clk) begin
      if (fft_load) begin
         wa_q.push_back(add_rd);
         wd_q.push_back(din);
         last_ld = cyc;
      end
      if (fft_start) begin
         n_start++;
         start_cyc = cyc;
      end
      if (note_valid) n_nv++;
      if (fft_load_t) last_ld_t = cyc;
      if (note_valid_t) n_nv_t++;
      if (timeout_err_t && !te_prev) begin
         te_cnt++;
         te_cyc = cyc;
      end
      te_prev = timeout_err_t;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      fft_done = 1'b0;
      clr_flags = 1'b0;
      sample_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic send(input int n, input bit idx_mode);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(1, 0)) step();
         sample = idx_mode ? 16'(i) : 16'($urandom);
         sample_valid = 1'b1;
         sent_q.push_back(sample);
         step();
         sample_valid = 1'b0;
      end
   endtask

   task automatic wait_start(input int s0);
      int b = 0;
      while (n_start == s0 && b < 200) begin
         step();
         b++;
      end
      total++;
      if (n_start - s0 !== 1) begin
         bad++;
         $display("FAIL start_count got=%0d exp=1", n_start - s0);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b0;
      sample_valid = 1'b0;
      sample = '0;
      fft_done = 1'b0;
      note_in = '0;
      clr_flags = 1'b0;
      step();
      step();
      total++;
      if ({fft_load, fft_start, add_rd, din, note, note_valid,
           busy, overrun, timeout_err} !== '0) begin
         bad++;
         $display("FAIL reset_outs got=%0d exp=0", busy);
      end
      reset = 1'b0;
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_busy got=%0d exp=0", busy);
      end
   endtask

   task automatic test_full_frame();
      int sb, wb, s0;
      do_reset();
      enable = 1'b1;
      step();
      sb = sent_q.size();
      wb = wa_q.size();
      s0 = n_start;
      send(2048, 1'b1);
      repeat (4) step();
      total++;
      if (wa_q.size() - wb !== 512) begin
         bad++;
         $display("FAIL frame_writes got=%0d exp=512", wa_q.size() - wb);
      end
      for (int k = 0; k < 512 && wb + k < wa_q.size(); k++) begin
         total++;
         if (wa_q[wb+k] !== 9'(k) || wd_q[wb+k] !== sent_q[sb+4*k]) begin
            bad++;
            $display("FAIL frame_wr%0d got=%0d/%0d exp=%0d/%0d", k,
                     wa_q[wb+k], wd_q[wb+k], k, sent_q[sb+4*k]);
         end
      end
      total++;
      if (n_start - s0 !== 1) begin
         bad++;
         $display("FAIL frame_starts got=%0d exp=1", n_start - s0);
      end
      total++;
      if (start_cyc !== last_ld + 1) begin
         bad++;
         $display("FAIL start_cycle got=%0d exp=%0d", start_cyc, last_ld + 1);
      end
      total++;
      if (busy !== 1'b1 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL wait_busy got=%0d/%0d exp=1/0", busy, overrun);
      end
   endtask

   task automatic test_note();
      int sb, wb, s0, nv0;
      while (cyc < start_cyc + 300) step();
      nv0 = n_nv;
      note_in = 10'd57;
      fft_done = 1'b1;
      repeat (3) step();
      total++;
      if (note !== 10'd57 || n_nv - nv0 !== 1) begin
         bad++;
         $display("FAIL note57 got=%0d/%0d exp=57/1", note, n_nv - nv0);
      end
      sb = sent_q.size();
      wb = wa_q.size();
      send(8, 1'b0);
      step();
      total++;
      if (wa_q.size() - wb !== 2 || wa_q[wb] !== 9'd0 ||
          wd_q[wb] !== sent_q[sb]) begin
         bad++;
         $display("FAIL reload got=%0d exp=2", wa_q.size() - wb);
      end
      fft_done = 1'b0;
      s0 = n_start;
      send(2040, 1'b0);
      wait_start(s0);
      total++;
      if (wa_q.size() - wb !== 512) begin
         bad++;
         $display("FAIL frame2_writes got=%0d exp=512", wa_q.size() - wb);
      end
      nv0 = n_nv;
      note_in = 10'd12;
      fft_done = 1'b1;
      repeat (3) step();
      fft_done = 1'b0;
      total++;
      if (note !== 10'd12 || n_nv - nv0 !== 1) begin
         bad++;
         $display("FAIL note12 got=%0d/%0d exp=12/1", note, n_nv - nv0);
      end
   endtask

   task automatic test_overrun();
      int sb, wb, s0, errs;
      sb = sent_q.size();
      wb = wa_q.size();
      s0 = n_start;
      send(2048, 1'b0);
      wait_start(s0);
      errs = 0;
      for (int k = 0; k < 512 && wb + k < wa_q.size(); k++)
         if (wa_q[wb+k] !== 9'(k) || wd_q[wb+k] !== sent_q[sb+4*k])
            errs++;
      total++;
      if (errs !== 0 || wa_q.size() - wb !== 512) begin
         bad++;
         $display("FAIL frame3 got=%0d exp=0", errs);
      end
      wb = wa_q.size();
      send(32, 1'b0);
      step();
      total++;
      if (overrun !== 1'b1 || wa_q.size() !== wb || busy !== 1'b1) begin
         bad++;
         $display("FAIL overrun got=%0d/%0d exp=1/0", overrun, wa_q.size() - wb);
      end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      step();
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL ovr_clear got=%0d exp=0", overrun);
      end
      clr_flags = 1'b1;
      sample_valid = 1'b1;
      sample = 16'($urandom);
      step();
      clr_flags = 1'b0;
      sample_valid = 1'b0;
      step();
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL ovr_setwins got=%0d exp=1", overrun);
      end
      enable = 1'b0;
      step();
      note_in = 10'd300;
      fft_done = 1'b1;
      repeat (3) step();
      fft_done = 1'b0;
      total++;
      if (note !== 10'd300 || busy !== 1'b0) begin
         bad++;
         $display("FAIL wait_noabort got=%0d/%0d exp=300/0", note, busy);
      end
   endtask

   task automatic test_timeout();
      int t0, nv0, b;
      do_reset();
      enable = 1'b1;
      step();
      t0 = te_cnt;
      nv0 = n_nv_t;
      send(2048, 1'b0);
      b = 0;
      while (te_cnt == t0 && b < 300) begin
         step();
         b++;
      end
      step();
      total++;
      if (te_cnt - t0 !== 1 || te_cyc !== last_ld_t + 100) begin
         bad++;
         $display("FAIL to_cycle got=%0d exp=%0d", te_cyc, last_ld_t + 100);
      end
      enable = 1'b0;
      step();
      total++;
      if (busy_t !== 1'b0 || timeout_err_t !== 1'b1) begin
         bad++;
         $display("FAIL to_idle got=%0d/%0d exp=0/1", busy_t, timeout_err_t);
      end
      total++;
      if (note_t !== 10'd0 || n_nv_t !== nv0) begin
         bad++;
         $display("FAIL to_note got=%0d/%0d exp=0/0", note_t, n_nv_t - nv0);
      end
   endtask

   task automatic test_edges();
      int sb, wb, s0, nv0, l;
      do_reset();
      enable = 1'b1;
      step();
      wb = wa_q.size();
      send(400, 1'b0);
      step();
      total++;
      if (wa_q.size() - wb !== 100 || busy !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset got=%0d exp=100", wa_q.size() - wb);
      end
      reset = 1'b1;
      #1;
      total++;
      if ({fft_load, add_rd, din, busy} !== '0) begin
         bad++;
         $display("FAIL async_reset got=%0d/%0d exp=0/0", add_rd, din);
      end
      step();
      reset = 1'b0;
      step();
      sb = sent_q.size();
      wb = wa_q.size();
      send(200, 1'b0);
      step();
      total++;
      if (wa_q.size() - wb !== 50 || wa_q[wb] !== 9'd0 ||
          wd_q[wb] !== sent_q[sb]) begin
         bad++;
         $display("FAIL post_reset got=%0d exp=50", wa_q.size() - wb);
      end
      s0 = n_start;
      enable = 1'b0;
      step();
      step();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL abort_idle got=%0d exp=0", busy);
      end
      enable = 1'b1;
      step();
      sb = sent_q.size();
      wb = wa_q.size();
      send(4, 1'b0);
      step();
      total++;
      if (wa_q.size() - wb !== 1 || wa_q[wb] !== 9'd0 || n_start !== s0) begin
         bad++;
         $display("FAIL abort_restart got=%0d exp=0", n_start - s0);
      end
      fft_done = 1'b1;
      send(2044, 1'b0);
      wait_start(s0);
      nv0 = n_nv;
      repeat (20) step();
      total++;
      if (n_nv !== nv0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL done_high got=%0d exp=0", n_nv - nv0);
      end
      fft_done = 1'b0;
      step();
      note_in = 10'd99;
      fft_done = 1'b1;
      repeat (3) step();
      fft_done = 1'b0;
      total++;
      if (note !== 10'd99 || n_nv - nv0 !== 1) begin
         bad++;
         $display("FAIL done_rerise got=%0d exp=99", note);
      end
      do_reset();
      enable = 1'b1;
      step();
      send(2048, 1'b0);
      step();
      step();
      l = last_ld_t;
      while (cyc < l + 99) step();
      note_in = 10'd77;
      fft_done = 1'b1;
      repeat (3) step();
      fft_done = 1'b0;
      total++;
      if (note_t !== 10'd77 || timeout_err_t !== 1'b0) begin
         bad++;
         $display("FAIL done_vs_to got=%0d/%0d exp=77/0", note_t, timeout_err_t);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_note();
      test_overrun();
      test_timeout();
      test_edges();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
